io_to_axi: RTL and testbench

Bridge from the IO bus (the strobe/ready bus driven by the CPU-side bridge) back onto the system's simplified AXI-lite bus. The IO bus is the target side; the AXI bus is the master side. Lets an external IO-bus initiator (debug port, DMA, second core) reach AXI responders. Holds one transaction at a time, with a bus timeout so a missing responder cannot hang the initiator.

---
 rtl/io_axi_pkg.sv | 24 ++
 rtl/io_axi_timer.sv | 33 +++
 rtl/io_to_axi.sv | 144 ++++++++++++++
 tb/tb_io_to_axi.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_axi_pkg.sv
// io_axi_pkg: shared definitions for the IO-bus to AXI-lite bridge.
//   state_t              - bridge FSM states
//   DEFAULT_TIMEOUT_DATA - read data returned for an abandoned transaction
//   cnt_width()          - timeout counter width for a given cycle limit
package io_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_REQ,
    S_W_RESP,
    S_R_REQ,
    S_R_RESP,
    S_DONE
  } state_t;

  localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEADBEEF;

  // A limit of 0 disables the timer; keep a 1-bit counter so the vector is legal.
  function automatic int unsigned cnt_width(input int unsigned limit);
    if (limit == 0) return 1;
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/io_axi_timer.sv
// io_axi_timer: clearable saturating cycle counter for the bridge timeout.
//   clk, rst  - clock, synchronous active-high reset
//   clear     - forces the count to 0 (priority over enable)
//   enable    - count this cycle
//   expired   - count has reached LIMIT (never asserted when LIMIT is 0)
module io_axi_timer
  import io_axi_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned WIDTH = cnt_width(LIMIT);
  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear || (LIMIT == 0)) begin
      count <= '0;
    end else if (enable && (count != LIMIT_W)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign expired = (LIMIT != 0) && (count == LIMIT_W);

endmodule

// File: rtl/io_to_axi.sv
// io_to_axi: IO-bus target to simplified AXI-lite master bridge, one
// transaction in flight, with a response timeout.
//   IO side : io_addr_strobe/io_read_strobe/io_write_strobe, io_addr,
//             io_byte_enable, io_write_data in; io_read_data, io_ready out
//   AXI side: wvalid/awaddr/wdata/wstrb out, wready/bvalid in;
//             arvalid/araddr out, arready/rvalid/rdata in
//   Status  : timeout (pulse with io_ready on abort), err_overlap (sticky)
module io_to_axi
  import io_axi_pkg::*;
#(
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [31:0] TIMEOUT_DATA = DEFAULT_TIMEOUT_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_addr_strobe,
  input  logic        io_read_strobe,
  input  logic        io_write_strobe,
  input  logic [31:0] io_addr,
  input  logic [3:0]  io_byte_enable,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        io_ready,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] awaddr,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  output logic        timeout,
  output logic        err_overlap
);

  state_t      state, state_next;
  logic        strobe;
  logic        in_txn;
  logic        expired;
  logic        capture;
  logic        abort;
  logic        finish_rd;
  logic        finish_wr;
  logic [31:0] addr_q;

  // Both qualifiers high is treated as a write; neither means no request.
  assign strobe = io_addr_strobe && (io_write_strobe || io_read_strobe);
  assign in_txn = (state == S_W_REQ) || (state == S_W_RESP) ||
                  (state == S_R_REQ) || (state == S_R_RESP);

  // Counter sits at 0 outside a transaction, so it restarts on REQ entry.
  io_axi_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_txn),
    .enable  (in_txn),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    abort      = 1'b0;
    finish_rd  = 1'b0;
    finish_wr  = 1'b0;
    case (state)
      S_IDLE: begin
        if (strobe) begin
          capture    = 1'b1;
          state_next = io_write_strobe ? S_W_REQ : S_R_REQ;
        end
      end
      S_W_REQ: begin
        if (wready)       state_next = S_W_RESP;
        else if (expired) abort      = 1'b1;
      end
      S_W_RESP: begin
        if (bvalid) begin
          state_next = S_DONE;
          finish_wr  = 1'b1;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      S_R_REQ: begin
        if (arready)      state_next = S_R_RESP;
        else if (expired) abort      = 1'b1;
      end
      S_R_RESP: begin
        if (rvalid) begin
          state_next = S_DONE;
          finish_rd  = 1'b1;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort) state_next = S_DONE;
  end

  // Handshake and completion outputs are registered from the next state so
  // they line up with the state they belong to and drop on abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      wvalid       <= 1'b0;
      arvalid      <= 1'b0;
      io_ready     <= 1'b0;
      timeout      <= 1'b0;
      err_overlap  <= 1'b0;
      io_read_data <= '0;
      addr_q       <= '0;
      wdata        <= '0;
      wstrb        <= '0;
    end else begin
      wvalid   <= (state_next == S_W_REQ);
      arvalid  <= (state_next == S_R_REQ);
      io_ready <= (state_next == S_DONE);
      timeout  <= abort;
      if (capture) begin
        addr_q <= io_addr;
        wdata  <= io_write_data;
        wstrb  <= io_byte_enable;
      end
      if (finish_rd)      io_read_data <= rdata;
      else if (finish_wr) io_read_data <= '0;
      else if (abort)     io_read_data <= TIMEOUT_DATA;
      if (strobe && (state != S_IDLE)) err_overlap <= 1'b1;
    end
  end

  assign awaddr = addr_q;
  assign araddr = addr_q;

endmodule

// File: tb/tb_io_to_axi.sv
module tb_io_to_axi;

  localparam int unsigned TO = 8;
  localparam logic [31:0] TD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_addr_strobe, io_read_strobe, io_write_strobe;
  logic [31:0] io_addr, io_write_data, io_read_data;
  logic [3:0]  io_byte_enable;
  logic        io_ready, wvalid, wready, bvalid, arvalid, arready, rvalid;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        timeout, err_overlap;

  int checks = 0;
  int failures = 0;
  int wv_cnt = 0;
  bit model_on = 1'b0;

  io_to_axi #(.TIMEOUT(TO), .TIMEOUT_DATA(TD)) dut (
    .clk(clk), .rst(rst),
    .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
    .io_write_strobe(io_write_strobe), .io_addr(io_addr),
    .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
    .io_read_data(io_read_data), .io_ready(io_ready),
    .wvalid(wvalid), .wready(wready), .awaddr(awaddr), .wdata(wdata),
    .wstrb(wstrb), .bvalid(bvalid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rdata(rdata),
    .timeout(timeout), .err_overlap(err_overlap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one open transaction, request then response,
  // abandoned once it has been open TO+1 cycles without progress.
  bit          m_open, m_req, m_wr, m_done, m_to, m_err;
  int          m_age;
  logic [31:0] m_addr, m_wd, m_rd;
  logic [3:0]  m_be;
  bit          m_strobe, m_progress;

  always @(posedge clk) begin
    if (rst) begin
      m_open = 0; m_req = 0; m_wr = 0; m_done = 0; m_to = 0; m_err = 0;
      m_age = 0; m_addr = '0; m_wd = '0; m_rd = '0; m_be = '0;
    end else begin
      m_strobe = io_addr_strobe && (io_write_strobe || io_read_strobe);
      if (m_done) begin
        m_done = 0; m_to = 0;
        if (m_strobe) m_err = 1;
      end else if (!m_open) begin
        if (m_strobe) begin
          m_open = 1; m_req = 1; m_wr = io_write_strobe; m_age = 0;
          m_addr = io_addr; m_wd = io_write_data; m_be = io_byte_enable;
        end
      end else begin
        if (m_strobe) m_err = 1;
        if (m_req) m_progress = m_wr ? wready : arready;
        else       m_progress = m_wr ? bvalid : rvalid;
        if (m_progress) begin
          if (m_req) m_req = 0;
          else begin
            m_open = 0; m_done = 1;
            m_rd = m_wr ? 32'h0 : rdata;
          end
        end else if (m_age == int'(TO)) begin
          m_open = 0; m_req = 0; m_done = 1; m_to = 1; m_rd = TD;
        end
        m_age++;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("m_io_ready", 32'(io_ready), 32'(m_done));
      chk("m_timeout", 32'(timeout), 32'(m_done && m_to));
      chk("m_wvalid", 32'(wvalid), 32'(m_open && m_req && m_wr));
      chk("m_arvalid", 32'(arvalid), 32'(m_open && m_req && !m_wr));
      chk("m_err_overlap", 32'(err_overlap), 32'(m_err));
      chk("m_io_read_data", io_read_data, m_rd);
      chk("m_awaddr", awaddr, m_addr);
      chk("m_araddr", araddr, m_addr);
      chk("m_wdata", wdata, m_wd);
      chk("m_wstrb", 32'(wstrb), 32'(m_be));
    end
    if (wvalid) wv_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be);
    io_addr_strobe = 1; io_write_strobe = wr; io_read_strobe = !wr;
    io_addr = a; io_write_data = d; io_byte_enable = be;
  endtask

  task automatic strobe_off();
    io_addr_strobe = 0; io_write_strobe = 0; io_read_strobe = 0;
    io_addr = '0; io_write_data = '0; io_byte_enable = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst = 1; strobe_off();
    wready = 0; bvalid = 0; arready = 0; rvalid = 0; rdata = '0;
    tick();
    model_on = 1;
    tick();
    rst = 0;
    chk("rst_io_ready", 32'(io_ready), 32'h0);
    chk("rst_valids", {30'b0, wvalid, arvalid}, 32'h0);
    chk("rst_flags", {30'b0, timeout, err_overlap}, 32'h0);
    chk("rst_data", io_read_data | awaddr | wdata, 32'h0);
    chk("rst_wstrb", 32'(wstrb), 32'h0);
    tick();

    // Write, immediate responder.
    strobe_req(1, 32'h40, 32'hA5A5A5A5, 4'b0011); wready = 1;
    tick();                                      // N+1
    strobe_off();
    chk("wr_wvalid", 32'(wvalid), 32'h1);
    chk("wr_awaddr", awaddr, 32'h40);
    chk("wr_wdata", wdata, 32'hA5A5A5A5);
    chk("wr_wstrb", 32'(wstrb), 32'h3);
    tick();                                      // N+2
    wready = 0; bvalid = 1;
    chk("wr_wvalid_drop", 32'(wvalid), 32'h0);
    tick();                                      // N+3
    bvalid = 0;
    chk("wr_io_ready", 32'(io_ready), 32'h1);
    chk("wr_read_data", io_read_data, 32'h0);
    tick();
    chk("wr_ready_pulse", 32'(io_ready), 32'h0);
    tick();

    // Read, stalled responder.
    strobe_req(0, 32'h80, '0, '0);
    tick();                                      // N+1
    strobe_off();
    for (int i = 0; i < 5; i++) begin
      chk("rd_arvalid_stall", 32'(arvalid), 32'h1);
      tick();
    end
    arready = 1;                                 // handshake N+6
    chk("rd_arvalid_hs", 32'(arvalid), 32'h1);
    tick();
    arready = 0;
    chk("rd_arvalid_drop", 32'(arvalid), 32'h0);
    tick();
    tick();
    rvalid = 1; rdata = 32'h12345678;            // N+9
    tick();
    rvalid = 0; rdata = '0;
    chk("rd_io_ready", 32'(io_ready), 32'h1);
    chk("rd_data", io_read_data, 32'h12345678);
    chk("rd_no_timeout", 32'(timeout), 32'h0);
    tick();
    tick();

    // Timeout with a silent responder, then a normal read right after.
    strobe_req(0, 32'h100, '0, '0);
    tick();
    strobe_off();
    cyc = 1;
    while (!io_ready && cyc < 20) begin
      if (cyc == 9) chk("to_arvalid_held", 32'(arvalid), 32'h1);
      tick();
      cyc++;
    end
    chk("to_latency", 32'(cyc), 32'd10);
    chk("to_timeout", 32'(timeout), 32'h1);
    chk("to_data", io_read_data, 32'hDEADBEEF);
    chk("to_arvalid_drop", 32'(arvalid), 32'h0);
    tick();
    strobe_req(0, 32'h104, '0, '0); arready = 1;
    tick();
    strobe_off();
    chk("to_next_arvalid", 32'(arvalid), 32'h1);
    tick();
    arready = 0; rvalid = 1; rdata = 32'hCAFEF00D;
    tick();
    rvalid = 0; rdata = '0;
    chk("to_next_ready", 32'(io_ready), 32'h1);
    chk("to_next_data", io_read_data, 32'hCAFEF00D);
    chk("to_next_no_timeout", 32'(timeout), 32'h0);
    tick();
    tick();

    // Response in the expiry cycle wins.
    strobe_req(0, 32'h180, '0, '0);
    tick();                                      // N+1
    strobe_off(); arready = 1;
    tick();                                      // N+2
    arready = 0;
    for (int i = 0; i < 7; i++) tick();          // N+9
    rvalid = 1; rdata = 32'h0BADC0DE;
    tick();
    rvalid = 0; rdata = '0;
    chk("tie_io_ready", 32'(io_ready), 32'h1);
    chk("tie_data", io_read_data, 32'h0BADC0DE);
    chk("tie_no_timeout", 32'(timeout), 32'h0);
    tick();
    tick();

    // Overlapping strobe in W_RESP.
    wv_cnt = 0;
    strobe_req(1, 32'h200, 32'h11112222, 4'hF); wready = 1;
    tick();                                      // N+1
    strobe_off();
    tick();                                      // N+2
    wready = 0;
    strobe_req(1, 32'h300, 32'h33334444, 4'h1);
    tick();                                      // N+3
    strobe_off(); bvalid = 1;
    chk("ov_err_set", 32'(err_overlap), 32'h1);
    tick();                                      // N+4
    bvalid = 0;
    chk("ov_io_ready", 32'(io_ready), 32'h1);
    chk("ov_awaddr_kept", awaddr, 32'h200);
    tick();
    tick();
    chk("ov_err_sticky", 32'(err_overlap), 32'h1);
    chk("ov_one_txn", 32'(wv_cnt), 32'h1);

    // Reset in R_RESP, then a late response in IDLE.
    strobe_req(0, 32'h400, '0, '0);
    tick();                                      // N+1
    strobe_off(); arready = 1;
    tick();                                      // N+2, R_RESP
    arready = 0; rst = 1;
    tick();
    rst = 0;
    chk("rr_io_ready", 32'(io_ready), 32'h0);
    chk("rr_flags", {29'b0, timeout, err_overlap, arvalid}, 32'h0);
    chk("rr_addr", araddr | io_read_data, 32'h0);
    rvalid = 1; rdata = 32'h55AA55AA;
    tick();
    rvalid = 0; rdata = '0;
    for (int i = 0; i < 5; i++) begin
      chk("rr_no_ready", 32'(io_ready), 32'h0);
      tick();
    end
    chk("rr_data_clear", io_read_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
